// File: rtl/bank_req_fifo_if.sv
// Request-queue bus between a PE/arbiter pair and bank_req_fifo.
// The master side drives pushes, read intent and grants. The slave side is the FIFO.
interface bank_req_fifo_if #(
  parameter int FIFO_PTR     = 4,
  parameter int FIFO_WIDTH   = 36,
  parameter int MEM_BANK_NUM = 16
);
  logic                    write_en;
  logic [FIFO_WIDTH-1:0]   write_data;
  logic                    read_en;
  logic [MEM_BANK_NUM-1:0] nxt_gnt;
  logic [FIFO_WIDTH-1:0]   read_data;
  logic [MEM_BANK_NUM-1:0] req_pea_to_bank;
  logic                    pop;
  logic                    wr_drop;
  logic                    full;
  logic                    empty;
  logic                    almost_full;
  logic [FIFO_PTR:0]       data_avail;
  logic [FIFO_PTR:0]       room_avail;
  logic                    starve;

  modport master (
    output write_en, write_data, read_en, nxt_gnt,
    input  read_data, req_pea_to_bank, pop, wr_drop, full, empty,
           almost_full, data_avail, room_avail, starve
  );

  modport slave (
    input  write_en, write_data, read_en, nxt_gnt,
    output read_data, req_pea_to_bank, pop, wr_drop, full, empty,
           almost_full, data_avail, room_avail, starve
  );
endinterface

// File: rtl/bank_req_fifo.sv
// Per-PE show-ahead request FIFO with peek-until-grant dequeue toward banked memory.
// Optional starvation monitor is enabled by defining BANK_REQ_FIFO_STARVE_EN.
module bank_req_fifo #(
  parameter int FIFO_PTR     = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_WIDTH   = 36,
  parameter int MEM_BANK_NUM = 16,
  parameter int BANK_SEL_W   = 4,
  parameter int BANK_SEL_LSB = 32,
  parameter int AF_THRESH    = 12,
  parameter int STARVE_W     = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  bank_req_fifo_if.slave  bus
);

  localparam logic [FIFO_PTR:0]   DEPTH_C = FIFO_DEPTH[FIFO_PTR:0];
  localparam logic [FIFO_PTR:0]   AF_C    = AF_THRESH[FIFO_PTR:0];
  localparam logic [FIFO_PTR:0]   CNT_ONE = {{FIFO_PTR{1'b0}}, 1'b1};
  localparam logic [FIFO_PTR-1:0] PTR_ONE = {{(FIFO_PTR-1){1'b0}}, 1'b1};

  // Storage is deliberately left out of reset; only pointers and count are cleared.
  logic [FIFO_WIDTH-1:0]   mem [FIFO_DEPTH];

  logic [FIFO_PTR-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [FIFO_PTR-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [FIFO_PTR:0]       num_entries_reg, num_entries_next;

  logic                    empty;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic [FIFO_WIDTH-1:0]   head;
  logic [BANK_SEL_W-1:0]   sel;
  logic [MEM_BANK_NUM-1:0] req;

  assign empty = (num_entries_reg == '0);
  assign full  = (num_entries_reg == DEPTH_C);
  assign head  = empty ? '0 : mem[rd_ptr_reg];
  assign sel   = head[BANK_SEL_LSB +: BANK_SEL_W];

  // One comparator per bank; a select value beyond the bank range matches none.
  for (genvar gi = 0; gi < MEM_BANK_NUM; gi++) begin : g_bank_req
    assign req[gi] = bus.read_en && !empty && (32'(sel) == gi);
  end

  assign pop  = |(req & bus.nxt_gnt);
  assign push = bus.write_en && (!full || pop);

  always_comb begin
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    num_entries_next = num_entries_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   num_entries_next = num_entries_reg + CNT_ONE;
      2'b01:   num_entries_next = num_entries_reg - CNT_ONE;
      default: num_entries_next = num_entries_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      num_entries_reg <= '0;
    end else begin
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      num_entries_reg <= num_entries_next;
    end
  end

  // A push into a full queue lands on the slot being popped; the head is read combinationally first.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.write_data;
    end
  end

  assign bus.read_data       = head;
  assign bus.req_pea_to_bank = req;
  assign bus.pop             = pop;
  assign bus.wr_drop         = bus.write_en && full && !pop;
  assign bus.full            = full;
  assign bus.empty           = empty;
  assign bus.almost_full     = (num_entries_reg >= AF_C);
  assign bus.data_avail      = num_entries_reg;
  assign bus.room_avail      = DEPTH_C - num_entries_reg;

`ifdef BANK_REQ_FIFO_STARVE_EN
  localparam logic [STARVE_W-1:0] STARVE_LIMIT_C = STARVE_LIMIT[STARVE_W-1:0];
  localparam logic [STARVE_W-1:0] STARVE_ONE     = {{(STARVE_W-1){1'b0}}, 1'b1};

  logic [STARVE_W-1:0] starve_cnt_reg, starve_cnt_next;

  // Counts consecutive cycles the head is requested but not granted; saturates at all-ones.
  always_comb begin
    starve_cnt_next = '0;
    if ((req != '0) && !pop) begin
      starve_cnt_next = (starve_cnt_reg == '1) ? starve_cnt_reg : starve_cnt_reg + STARVE_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  assign bus.starve = (starve_cnt_reg >= STARVE_LIMIT_C);
`else
  // Monitor not built; the limit parameters only feed this elaboration-time guard.
  if (STARVE_LIMIT < 0 || STARVE_W < 1) begin : g_starve_params_invalid
  end
  assign bus.starve = 1'b0;
`endif

endmodule

// File: tb/tb_bank_req_fifo.sv
// Randomised and directed bench for bank_req_fifo against a queue-based reference model.
// The model tracks the starvation flag only when BANK_REQ_FIFO_STARVE_EN is defined.
module tb_bank_req_fifo;

`ifdef BANK_REQ_FIFO_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bank_req_fifo_if #(.FIFO_PTR(4), .FIFO_WIDTH(36), .MEM_BANK_NUM(16)) bus_if ();

  bank_req_fifo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  int txn          = 0;

  logic [35:0] model_q[$];
  int          starve_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h (txn %0d)", tag, got, exp, txn);
    end
  endtask

  function automatic logic [15:0] head_gnt();
    logic [15:0] g;
    logic [35:0] h;
    g = '0;
    if (model_q.size() > 0) begin
      h = model_q[0];
      g[h[35:32]] = 1'b1;
    end
    return g;
  endfunction

  // One clock of stimulus: drive at negedge, check all outputs against the model, advance model at posedge.
  task automatic cycle(input logic we, input logic [35:0] wd, input logic re, input logic [15:0] gnt);
    logic [35:0] e_rd;
    logic [15:0] e_req;
    logic        e_pop, e_push, e_drop, e_starve;
    int          n;
    @(negedge clk);
    bus_if.write_en   = we;
    bus_if.write_data = wd;
    bus_if.read_en    = re;
    bus_if.nxt_gnt    = gnt;
    #2;
    n     = model_q.size();
    e_rd  = (n == 0) ? 36'h0 : model_q[0];
    e_req = '0;
    if (re && n > 0) e_req[e_rd[35:32]] = 1'b1;
    e_pop    = (e_req & gnt) != 16'h0;
    e_drop   = we && (n == 16) && !e_pop;
    e_push   = we && ((n < 16) || e_pop);
    e_starve = STARVE_ON && (starve_cnt >= 8);
    check_eq("read_data",   bus_if.read_data,       e_rd);
    check_eq("req",         bus_if.req_pea_to_bank, e_req);
    check_eq("pop",         bus_if.pop,             e_pop);
    check_eq("wr_drop",     bus_if.wr_drop,         e_drop);
    check_eq("full",        bus_if.full,            n == 16);
    check_eq("empty",       bus_if.empty,           n == 0);
    check_eq("almost_full", bus_if.almost_full,     n >= 12);
    check_eq("data_avail",  bus_if.data_avail,      n);
    check_eq("room_avail",  bus_if.room_avail,      16 - n);
    check_eq("starve",      bus_if.starve,          e_starve);
    @(posedge clk);
    if (e_pop) void'(model_q.pop_front());
    if (e_push) model_q.push_back(wd);
    if (e_req != 16'h0 && !e_pop) begin
      if (starve_cnt < 255) starve_cnt++;
    end else begin
      starve_cnt = 0;
    end
    $display("txn %0d we=%0b re=%0b gnt=%04h pop=%0b drop=%0b cnt=%0d", txn, we, re, gnt, e_pop, e_drop, model_q.size());
    txn++;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_empty"}, bus_if.empty,           1);
    check_eq({tag, "_full"},  bus_if.full,            0);
    check_eq({tag, "_af"},    bus_if.almost_full,     0);
    check_eq({tag, "_avail"}, bus_if.data_avail,      0);
    check_eq({tag, "_room"},  bus_if.room_avail,      16);
    check_eq({tag, "_rdata"}, bus_if.read_data,       0);
    check_eq({tag, "_req"},   bus_if.req_pea_to_bank, 0);
    check_eq({tag, "_pop"},   bus_if.pop,             0);
    check_eq({tag, "_drop"},  bus_if.wr_drop,         0);
    check_eq({tag, "_starve"},bus_if.starve,          0);
  endtask

  // Asynchronous reset asserted between edges, held 3 cycles, released at a negedge.
  task automatic reset_mid(input string tag);
    @(negedge clk);
    bus_if.write_en = 1'b0;
    bus_if.read_en  = 1'b1;
    bus_if.nxt_gnt  = 16'h0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_state(tag);
    model_q.delete();
    starve_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("txn %0d reset %s", txn, tag);
    txn++;
  endtask

  initial begin
    logic [35:0] wd;
    logic [15:0] g;
    int          r;
    bus_if.write_en   = 1'b0;
    bus_if.write_data = '0;
    bus_if.read_en    = 1'b0;
    bus_if.nxt_gnt    = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("por");
    @(negedge clk);
    rst = 1'b0;

    // Partial fill, then reset discards everything.
    for (int i = 0; i < 5; i++) cycle(1'b1, {4'(i), 32'h1000_0000 + 32'(i)}, 1'b0, 16'h0);
    reset_mid("midfill");
    cycle(1'b0, 36'h0, 1'b1, 16'hFFFF);

    // Peek without pop, then matching grant.
    cycle(1'b1, {4'h6, 32'hDEADBEEF}, 1'b0, 16'h0);
    repeat (5) begin
      cycle(1'b0, 36'h0, 1'b1, 16'h0);
      check_eq("peek_req_held", bus_if.req_pea_to_bank, 16'h0040);
    end
    cycle(1'b0, 36'h0, 1'b1, 16'h0040);
    cycle(1'b0, 36'h0, 1'b0, 16'h0);
    check_eq("peek_empty_after", bus_if.empty, 1);

    // Wrong-bank grant and grant without read_en.
    cycle(1'b1, {4'h1, 32'h0000_1111}, 1'b0, 16'h0);
    repeat (3) cycle(1'b0, 36'h0, 1'b1, 16'h0004);
    cycle(1'b0, 36'h0, 1'b0, 16'h0002);
    cycle(1'b0, 36'h0, 1'b1, 16'h0002);

    // Fill to full, drop, write-plus-pop while full, then drain across the wrap.
    for (int i = 0; i < 16; i++) cycle(1'b1, {4'(i), 32'hA000_0000 + 32'(i)}, 1'b0, 16'h0);
    cycle(1'b1, {4'h3, 32'hBAD0_0000}, 1'b1, 16'h0);
    check_eq("full_drop_count", bus_if.data_avail, 16);
    cycle(1'b1, {4'h5, 32'hB000_0010}, 1'b1, head_gnt());
    cycle(1'b0, 36'h0, 1'b0, 16'h0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 36'h0, 1'b1, head_gnt());
    cycle(1'b0, 36'h0, 1'b1, 16'hFFFF);

    // Starvation: head requested but never granted, then granted.
    cycle(1'b1, {4'h9, 32'h5A5A_5A5A}, 1'b0, 16'h0);
    repeat (12) cycle(1'b0, 36'h0, 1'b1, 16'h0);
    cycle(1'b0, 36'h0, 1'b1, 16'h0200);
    cycle(1'b0, 36'h0, 1'b0, 16'h0);
    check_eq("starve_clear", bus_if.starve, 0);

    // Randomised traffic with an arbiter that usually, but not always, grants the head bank.
    for (int k = 0; k < 400; k++) begin
      wd = {4'($urandom_range(0, 15)), 32'($urandom)};
      r  = int'($urandom_range(0, 3));
      case (r)
        0:       g = 16'h0;
        1:       g = 16'($urandom);
        default: g = head_gnt();
      endcase
      if (k % 97 == 50) reset_mid("rand");
      cycle($urandom_range(0, 9) < 6, wd, $urandom_range(0, 9) < 7, (k % 64 < 20) ? 16'h0 : g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/bank_req_fifo.md
# bank_req_fifo

Per-PE request queue between a CGRA processing element and the shared-memory arbiter. Buffers memory requests, presents the head entry as a one-hot bank request, and dequeues it only when the arbiter grants that bank (peek-until-grant). This generalises the earlier single-mode request FIFO with:
- a configurable bank-select field;
- an almost-full watermark;
- write-drop reporting;
- an optional starvation monitor.

## Interface
- FIFO_PTR, 4, pointer width; depth = 2**FIFO_PTR
- FIFO_DEPTH, 16, entries; must equal 2**FIFO_PTR
- FIFO_WIDTH, 36, request word width
- MEM_BANK_NUM, 16, number of memory banks
- BANK_SEL_W, 4, bank-select field width
- BANK_SEL_LSB, 32, bit position of the bank-select field in the request word
- AF_THRESH, 12, almost_full asserts when the entry count is at or above this value
- STARVE_W, 8, starvation counter width
- STARVE_LIMIT, 8, wait cycles before starve asserts
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- write_en  in  1  push request
- write_data  in  FIFO_WIDTH  request word
- read_en  in  1  PE wants head presented to arbiter
- nxt_gnt  in  MEM_BANK_NUM  arbiter grant vector
- read_data  out  FIFO_WIDTH  head entry; 0 when empty
- req_pea_to_bank  out  MEM_BANK_NUM  one-hot bank request for head
- pop  out  1  head dequeued this cycle
- wr_drop  out  1  write rejected (full, no pop)
- full, empty, almost_full  out  1  status flags
- data_avail, room_avail  out  FIFO_PTR+1  entry count; free slots
- starve  out  1  head waiting at least STARVE_LIMIT cycles

## Operation
- Storage: FIFO_DEPTH×FIFO_WIDTH register array. The array is not reset. Pointers are registered, FIFO_PTR wide, and wrap naturally from 15 to 0.
- Count: num_entries is registered, FIFO_PTR+1 bits.
  - full = (num_entries == FIFO_DEPTH); empty = (num_entries == 0); almost_full = (num_entries >= AF_THRESH).
  - data_avail = num_entries; room_avail = FIFO_DEPTH − num_entries.
- Show-ahead head: read_data = empty ? 0 : mem[rd_ptr].
- Bank select: sel = read_data[BANK_SEL_LSB +: BANK_SEL_W].
  - req_pea_to_bank = (read_en && !empty && sel < MEM_BANK_NUM) ? (1 << sel) : 0.
  - An out-of-range sel gives req 0; the entry stays stuck and starve will flag it.
- pop = |(req_pea_to_bank & nxt_gnt). Grant bits for other banks are ignored. read_en without a matching grant leaves the FIFO unchanged.
- push = write_en && (!full || pop). A push while full is accepted when a pop happens in the same cycle; the count is unchanged.
- wr_drop = write_en && full && !pop. It is combinational, and the data is discarded.
- Count update: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Starvation (with macro):
  - The counter increments each cycle req_pea_to_bank != 0 && !pop, and saturates at 2**STARVE_W−1.
  - It clears on pop, when req is 0, or on reset.
  - starve = (counter >= STARVE_LIMIT), registered-count derived.

## Timing
- Reset values: empty=1, full=0, almost_full=0, data_avail=0, room_avail=FIFO_DEPTH, read_data=0, req_pea_to_bank=0, pop=0, wr_drop=0, starve=0.
- Reset mid-operation discards all entries immediately (async).
- Push-to-head latency is 1 cycle: data written at edge N is on read_data, and req is valid, after edge N.
- Pop is decided combinationally in the same cycle as the grant. The next entry appears after that edge.
- Back-to-back grants drain one entry per cycle.
- Grant-to-pop has zero latency. The arbiter must present nxt_gnt in the cycle req is observed.

## Configuration
- BANK_REQ_FIFO_STARVE_EN
  - Defined: starvation counter and starve output logic are present as described.
  - Undefined: counter is not built, and starve is tied to 0.
  - All other behaviour is identical in both cases.

## Test plan
- Reset: assert rst for 3 cycles mid-fill → empty=1, data_avail=0, room_avail=16, req_pea_to_bank=0, read_data=0.
- Peek without pop: write {4'h6,32'hDEADBEEF}, read_en=1, nxt_gnt=0 for 5 cycles → req_pea_to_bank=16'h0040 held, data_avail=1. Then nxt_gnt=16'h0040 → pop=1 that cycle, empty=1 next.
- Wrong grant: head bank 1, nxt_gnt=16'h0004 → pop=0, req=16'h0002 held. With read_en=0 and nxt_gnt=16'h0002 → req=0, pop=0.
- Fill/wrap:
  - 16 writes → almost_full rises after the 12th push, full after the 16th.
  - A 17th write with no grant → wr_drop=1, count 16.
  - Write plus granted pop while full → count stays 16.
  - Draining 16 entries returns data in write order across the pointer wrap.
- Starvation (macro on, STARVE_LIMIT=8): head ungranted with read_en=1 → starve rises 8 cycles after req first asserts. Grant → pop, and starve=0 next cycle.
- Starvation (macro off): same stimulus → starve stays 0 throughout.
